// File: rtl/ssb_sync_pkg.sv
// rtl/ssb_sync_pkg.sv - frame-sync state encoding shared with the receiver register map
package ssb_sync_pkg;

    localparam int FS_STATE_W = 2;

    typedef enum logic [FS_STATE_W-1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        SYNCED  = 2'd2,
        HOLD    = 2'd3
    } fs_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Clear wins over increment; the count sticks at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ssb_sync_monitor.sv
// rtl/ssb_sync_monitor.sv - SSB periodicity tracker and frame-sync FSM; SSB_SYNC_MONITOR_SPURIOUS_CNT_EN adds spurious_cnt_o
module ssb_sync_monitor
    import ssb_sync_pkg::*;
#(
    parameter int SSB_PERIOD = 76800,
    parameter int TOL        = 8,
    parameter int MAX_MISSED = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  sample_valid_i,
    input  logic                  ssb_detected_i,
    input  logic [1:0]            N_id_2_i,
    output logic [FS_STATE_W-1:0] fs_state_o,
    output logic [1:0]            N_id_2_o,
    output logic [7:0]            sample_cnt_mismatch_o,
    output logic [15:0]           missed_SSBs_o,
`ifdef SSB_SYNC_MONITOR_SPURIOUS_CNT_EN
    output logic [15:0]           spurious_cnt_o,
`endif
    output logic                  ssb_start_o
);

    localparam int CW = $clog2(SSB_PERIOD + TOL + 1);
    localparam int MW = $clog2(MAX_MISSED + 1);

    localparam logic [CW-1:0] WIN_LO      = CW'(SSB_PERIOD - TOL);
    localparam logic [CW-1:0] WIN_HI      = CW'(SSB_PERIOD + TOL);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] MISS_RELOAD = CW'(TOL + 1);
    localparam logic [MW-1:0] LAST_MISS   = MW'(MAX_MISSED - 1);

    fs_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    n_id_2_q, n_id_2_d;
    logic [7:0]    mismatch_q, mismatch_d;
    logic          start_q, start_d;
    logic [MW-1:0] consec;

    logic det, in_win, close, tracking, accept, miss, give_up;

    // Detection qualification against the expected-SSB window
    always_comb begin
        det      = sample_valid_i & ssb_detected_i;
        in_win   = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
        close    = sample_valid_i && (cnt_q == WIN_HI);
        tracking = (state_q != SEARCH);
        accept   = tracking & det & in_win & (N_id_2_i == n_id_2_q);
        miss     = close & ~accept & ((state_q == SYNCED) || (state_q == HOLD));
        give_up  = miss && (consec == LAST_MISS);
    end

    // Next state, sample index and registered outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_id_2_d   = n_id_2_q;
        mismatch_d = mismatch_q;
        start_d    = accept | miss;

        case (state_q)
            SEARCH: begin
                if (det) begin
                    state_d  = CONFIRM;
                    n_id_2_d = N_id_2_i;
                end
            end
            CONFIRM: begin
                if (accept) begin
                    state_d = SYNCED;
                end else if (close) begin
                    state_d = SEARCH;
                end
            end
            SYNCED, HOLD: begin
                if (accept) begin
                    state_d = SYNCED;
                end else if (miss) begin
                    state_d = give_up ? SEARCH : HOLD;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (sample_valid_i) begin
            if (accept || ((state_q == SEARCH) && det)) begin
                cnt_d = CNT_ONE;
            end else if (miss) begin
                // Flywheel: pretend the SSB arrived at the nominal sample
                cnt_d = MISS_RELOAD;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (accept) begin
            mismatch_d = 8'(32'(cnt_q) - 32'(SSB_PERIOD));
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= SEARCH;
            cnt_q      <= '0;
            n_id_2_q   <= '0;
            mismatch_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_id_2_q   <= n_id_2_d;
            mismatch_q <= mismatch_d;
            start_q    <= start_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_missed (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (miss),
        .clr_i    (1'b0),
        .count_o  (missed_SSBs_o)
    );

    sat_counter #(.WIDTH(MW)) u_consec (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (miss),
        .clr_i    (accept | give_up),
        .count_o  (consec)
    );

`ifdef SSB_SYNC_MONITOR_SPURIOUS_CNT_EN
    logic ignored;

    // A detection seen while tracking that was not taken as the SSB
    always_comb begin
        ignored = det & tracking & ~accept;
    end

    sat_counter #(.WIDTH(16)) u_spurious (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (ignored),
        .clr_i    (1'b0),
        .count_o  (spurious_cnt_o)
    );
`endif

    assign fs_state_o            = state_q;
    assign N_id_2_o              = n_id_2_q;
    assign sample_cnt_mismatch_o = mismatch_q;
    assign ssb_start_o           = start_q;

endmodule
